counter_arb_ctrl: RTL and testbench

COUNTER_ARB_CTRL -- requirements
Module: counter_arb_ctrl

---
 rtl/counter_arb_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_arb_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_arb_ctrl.sv
// Two-requester arbiter sequencing a shared counter through LOAD, RUN and DONE.
// Define CNT_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins.
module counter_arb_ctrl #(
  parameter int NUM_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [NUM_W-1:0] i_num0,
  input  logic [NUM_W-1:0] i_num1,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic             o_cnt_load,
  output logic             o_cnt_run,
  output logic [NUM_W-1:0] o_cnt_num,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sel;
  logic             win1;
  logic             any_req;
  logic [NUM_W-1:0] num_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  assign any_req = i_req0 | i_req1;

`ifdef CNT_ARB_ROUND_ROBIN_EN
  // last holds the requester served most recently; the other one wins a tie
  logic last;

  assign win1 = i_req1 & (~i_req0 | ~last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (state == LOAD) begin
      last <= sel;
    end
  end
`else
  assign win1 = i_req1 & ~i_req0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = (len_q != '0) ? RUN : DONE;
      end
      RUN: begin
        if (cnt == LEN_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // cnt is loaded in LOAD so RUN lasts exactly len_q cycles, never wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel   <= 1'b0;
      num_q <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        sel   <= win1;
        num_q <= win1 ? i_num1 : i_num0;
        len_q <= win1 ? i_len1 : i_len0;
      end
      if (state == LOAD) begin
        cnt <= len_q;
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_gnt0     = o_busy & ~sel;
  assign o_gnt1     = o_busy & sel;
  assign o_cnt_load = (state == LOAD);
  assign o_cnt_run  = (state == RUN);
  assign o_done0    = (state == DONE) & ~sel;
  assign o_done1    = (state == DONE) & sel;
  assign o_cnt_num  = num_q;

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Directed bench for counter_arb_ctrl.
// Output vector order: {gnt0, gnt1, load, run, done0, done1, busy}.
module tb_counter_arb_ctrl;

  logic       clk;
  logic       reset;
  logic       i_req0, i_req1;
  logic [3:0] i_num0, i_num1;
  logic [7:0] i_len0, i_len1;
  logic       o_gnt0, o_gnt1, o_done0, o_done1;
  logic       o_cnt_load, o_cnt_run, o_busy;
  logic [3:0] o_cnt_num;
  logic [6:0] ov;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_LOAD0 = 7'b1010001;
  localparam logic [6:0] V_RUN0  = 7'b1001001;
  localparam logic [6:0] V_DONE0 = 7'b1000101;
  localparam logic [6:0] V_LOAD1 = 7'b0110001;
  localparam logic [6:0] V_RUN1  = 7'b0101001;
  localparam logic [6:0] V_DONE1 = 7'b0100011;

  counter_arb_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_num0     (i_num0),
    .i_num1     (i_num1),
    .i_len0     (i_len0),
    .i_len1     (i_len1),
    .o_gnt0     (o_gnt0),
    .o_gnt1     (o_gnt1),
    .o_done0    (o_done0),
    .o_done1    (o_done1),
    .o_cnt_load (o_cnt_load),
    .o_cnt_run  (o_cnt_run),
    .o_cnt_num  (o_cnt_num),
    .o_busy     (o_busy)
  );

  assign ov = {o_gnt0, o_gnt1, o_cnt_load, o_cnt_run,
               o_done0, o_done1, o_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    i_req0 = 0; i_req1 = 0;
    i_num0 = 0; i_num1 = 0;
    i_len0 = 0; i_len1 = 0;
    #2;
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=%b", ov, V_IDLE);
    end
    checks++;
    if (o_cnt_num !== 4'd0) begin
      errors++;
      $display("FAIL reset_num got=%0d exp=0", o_cnt_num);
    end
    i_req0 = 1;
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", ov, V_IDLE);
    end
    i_req0 = 0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    i_req0 = 1; i_num0 = 3; i_len0 = 5;
    step();
    checks++;
    if (ov !== V_LOAD0 || o_cnt_num !== 4'd3) begin
      errors++;
      $display("FAIL single_load got=%b/%0d exp=%b/3", ov, o_cnt_num, V_LOAD0);
    end
    i_req0 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ov !== V_RUN0 || o_cnt_num !== 4'd3) begin
        errors++;
        $display("FAIL single_run%0d got=%b exp=%b", i, ov, V_RUN0);
      end
    end
    step();
    checks++;
    if (ov !== V_DONE0) begin
      errors++;
      $display("FAIL single_done got=%b exp=%b", ov, V_DONE0);
    end
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL single_idle got=%b exp=%b", ov, V_IDLE);
    end
  endtask

  task automatic test_zero_len();
    i_req1 = 1; i_num1 = 7; i_len1 = 0;
    step();
    checks++;
    if (ov !== V_LOAD1 || o_cnt_num !== 4'd7) begin
      errors++;
      $display("FAIL zero_load got=%b/%0d exp=%b/7", ov, o_cnt_num, V_LOAD1);
    end
    i_req1 = 0;
    step();
    checks++;
    if (ov !== V_DONE1) begin
      errors++;
      $display("FAIL zero_done got=%b exp=%b", ov, V_DONE1);
    end
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL zero_idle got=%b exp=%b", ov, V_IDLE);
    end
  endtask

  task automatic test_priority();
    logic [3:0] win;
    logic [3:0] enum_exp;
    logic [6:0] vl, vr, vd;
`ifdef CNT_ARB_ROUND_ROBIN_EN
    win = 4'b1010;
`else
    win = 4'b0000;
`endif
    do_reset();
    i_num0 = 3; i_num1 = 2; i_len0 = 1; i_len1 = 1;
    i_req0 = 1; i_req1 = 1;
    for (int g = 0; g < 4; g++) begin
      vl = win[g] ? V_LOAD1 : V_LOAD0;
      vr = win[g] ? V_RUN1  : V_RUN0;
      vd = win[g] ? V_DONE1 : V_DONE0;
      enum_exp = win[g] ? 4'd2 : 4'd3;
      step();
      checks++;
      if (ov !== vl || o_cnt_num !== enum_exp) begin
        errors++;
        $display("FAIL prio_load%0d got=%b/%0d exp=%b/%0d",
                 g, ov, o_cnt_num, vl, enum_exp);
      end
      step();
      checks++;
      if (ov !== vr) begin
        errors++;
        $display("FAIL prio_run%0d got=%b exp=%b", g, ov, vr);
      end
      step();
      checks++;
      if (ov !== vd) begin
        errors++;
        $display("FAIL prio_done%0d got=%b exp=%b", g, ov, vd);
      end
      if (g == 3) begin
        i_req0 = 0; i_req1 = 0;
      end
      step();
      checks++;
      if (ov !== V_IDLE) begin
        errors++;
        $display("FAIL prio_idle%0d got=%b exp=%b", g, ov, V_IDLE);
      end
    end
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL prio_quiet got=%b exp=%b", ov, V_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    i_req1 = 1; i_num1 = 4; i_len1 = 2; i_req0 = 0;
    step();
    checks++;
    if (ov !== V_LOAD1) begin
      errors++;
      $display("FAIL b2b_load got=%b exp=%b", ov, V_LOAD1);
    end
    step();
    step();
    step();
    checks++;
    if (ov !== V_DONE1) begin
      errors++;
      $display("FAIL b2b_done got=%b exp=%b", ov, V_DONE1);
    end
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL b2b_gap got=%b exp=%b", ov, V_IDLE);
    end
    step();
    checks++;
    if (ov !== V_LOAD1) begin
      errors++;
      $display("FAIL b2b_reload got=%b exp=%b", ov, V_LOAD1);
    end
    i_req1 = 0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL b2b_end got=%b exp=%b", ov, V_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    i_req0 = 1; i_num0 = 5; i_len0 = 8;
    step();
    step();
    step();
    step();
    checks++;
    if (ov !== V_RUN0) begin
      errors++;
      $display("FAIL rmid_run3 got=%b exp=%b", ov, V_RUN0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ov !== V_IDLE || o_cnt_num !== 4'd0) begin
      errors++;
      $display("FAIL rmid_abort got=%b/%0d exp=%b/0", ov, o_cnt_num, V_IDLE);
    end
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL rmid_held got=%b exp=%b", ov, V_IDLE);
    end
    reset = 1'b0;
    step();
    checks++;
    if (ov !== V_LOAD0 || o_cnt_num !== 4'd5) begin
      errors++;
      $display("FAIL rmid_regrant got=%b/%0d exp=%b/5", ov, o_cnt_num, V_LOAD0);
    end
    i_req0 = 0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (ov !== V_RUN0) begin
      errors++;
      $display("FAIL rmid_lastrun got=%b exp=%b", ov, V_RUN0);
    end
    step();
    checks++;
    if (ov !== V_DONE0) begin
      errors++;
      $display("FAIL rmid_done got=%b exp=%b", ov, V_DONE0);
    end
    step();
  endtask

  task automatic test_mid_change();
    i_req0 = 1; i_num0 = 3; i_len0 = 4;
    step();
    checks++;
    if (ov !== V_LOAD0 || o_cnt_num !== 4'd3) begin
      errors++;
      $display("FAIL chg_load got=%b/%0d exp=%b/3", ov, o_cnt_num, V_LOAD0);
    end
    step();
    i_req0 = 0; i_num0 = 9; i_len0 = 1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (ov !== V_RUN0 || o_cnt_num !== 4'd3) begin
        errors++;
        $display("FAIL chg_run%0d got=%b/%0d exp=%b/3",
                 i, ov, o_cnt_num, V_RUN0);
      end
    end
    step();
    checks++;
    if (ov !== V_DONE0 || o_cnt_num !== 4'd3) begin
      errors++;
      $display("FAIL chg_done got=%b/%0d exp=%b/3", ov, o_cnt_num, V_DONE0);
    end
    step();
    checks++;
    if (ov !== V_IDLE || o_cnt_num !== 4'd3) begin
      errors++;
      $display("FAIL chg_idle got=%b/%0d exp=%b/3", ov, o_cnt_num, V_IDLE);
    end
  endtask

  task automatic test_max_len();
    int runs;
    int bad;
    runs = 0;
    bad  = 0;
    i_req0 = 1; i_num0 = 15; i_len0 = 8'd255;
    step();
    checks++;
    if (ov !== V_LOAD0 || o_cnt_num !== 4'd15) begin
      errors++;
      $display("FAIL max_load got=%b/%0d exp=%b/15", ov, o_cnt_num, V_LOAD0);
    end
    i_req0 = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (ov === V_RUN0) runs++;
      else if (ov !== V_DONE0 || runs != 255) bad++;
      if (ov !== V_RUN0) break;
    end
    checks++;
    if (runs != 255) begin
      errors++;
      $display("FAIL max_runs got=%0d exp=255", runs);
    end
    checks++;
    if (bad != 0 || ov !== V_DONE0) begin
      errors++;
      $display("FAIL max_done got=%b exp=%b", ov, V_DONE0);
    end
    step();
    checks++;
    if (ov !== V_IDLE) begin
      errors++;
      $display("FAIL max_idle got=%b exp=%b", ov, V_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_mid_change();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
